// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, full/empty/almost-full flags and registered read data.
// Define SYNC_FIFO_ERR_EN to build the sticky overflow/underflow flags.
module sync_fifo #(
  parameter int W        = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          wr_ok;
  logic          rd_ok;

  // Acceptance uses pre-edge flags only, so a full FIFO rejects a write
  // even when a read drains an entry in the same cycle.
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign almost_full = (count >= CW'(AF_LEVEL));

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wp] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      if (wr_ok) begin
        wp <= wp + AW'(1);
      end
      if (rd_ok) begin
        rp      <= rp + AW'(1);
        rd_data <= mem[rp];
      end
      unique case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef SYNC_FIFO_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: directed vector table plus randomized traffic
// checked against a queue-based reference model.
module tb_sync_fifo;

  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int AFL   = 3;
  localparam int CW    = $clog2(DEPTH) + 1;

`ifdef SYNC_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [W-1:0]  wr_data;
  logic          rd_en;
  logic [W-1:0]  rd_data;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic [CW-1:0] count;
  logic          overflow;
  logic          underflow;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  sync_fifo #(
    .W(W),
    .DEPTH(DEPTH),
    .AF_LEVEL(AFL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .count(count),
    .overflow(overflow),
    .underflow(underflow)
  );

  // count, rd_valid, rd_data, full, empty, almost_full, overflow, underflow
  typedef logic [CW+W+5:0] obs_t;

  typedef struct {
    string        name;
    logic         rst;
    logic         we;
    logic [W-1:0] wd;
    logic         re;
    int           cnt;
    logic         v;
    logic [W-1:0] d;
    logic         f;
    logic         e;
    logic         af;
    logic         o;
    logic         u;
  } vec_t;

  vec_t vecs[$];

  function automatic obs_t pack(int cnt, logic v, logic [W-1:0] d,
                                logic f, logic e, logic af,
                                logic o, logic u);
    return {CW'(cnt), v, d, f, e, af, o & ERR_EN, u & ERR_EN};
  endfunction

  function automatic obs_t dut_obs();
    return {count, rd_valid, rd_data, full, empty, almost_full,
            overflow, underflow};
  endfunction

  task automatic chk(string name, obs_t act, obs_t exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      passed++;
  endtask

  task automatic cyc(logic r, logic we, logic [W-1:0] wd, logic re);
    rst     = r;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    @(posedge clk);
    #1;
  endtask

  function automatic void add(string n, logic r, logic we, logic [W-1:0] wd,
                              logic re, int c, logic v, logic [W-1:0] d,
                              logic f, logic e, logic af, logic o, logic u);
    vec_t t;
    t.name = n; t.rst = r; t.we = we; t.wd = wd; t.re = re;
    t.cnt = c; t.v = v; t.d = d; t.f = f; t.e = e; t.af = af;
    t.o = o; t.u = u;
    vecs.push_back(t);
  endfunction

  // reference model state
  logic [W-1:0] q[$];
  logic         m_v;
  logic [W-1:0] m_d;
  logic         m_o;
  logic         m_u;

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;

    //   name        rst we wd     re cnt v  d      f  e  af o  u
    add("reset",      1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0);
    add("idle1",      0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0);
    add("idle2",      0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0);
    add("idle3",      0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0);
    add("wr11",       0, 1, 8'h11, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0);
    add("wr22",       0, 1, 8'h22, 0, 2, 0, 8'h00, 0, 0, 0, 0, 0);
    add("wr33_af",    0, 1, 8'h33, 0, 3, 0, 8'h00, 0, 0, 1, 0, 0);
    add("wr44_full",  0, 1, 8'h44, 0, 4, 0, 8'h00, 1, 0, 1, 0, 0);
    add("wr55_rej",   0, 1, 8'h55, 0, 4, 0, 8'h00, 1, 0, 1, 1, 0);
    add("rd11",       0, 0, 8'h00, 1, 3, 1, 8'h11, 0, 0, 1, 1, 0);
    add("rd22",       0, 0, 8'h00, 1, 2, 1, 8'h22, 0, 0, 0, 1, 0);
    add("rd33",       0, 0, 8'h00, 1, 1, 1, 8'h33, 0, 0, 0, 1, 0);
    add("rd44",       0, 0, 8'h00, 1, 0, 1, 8'h44, 0, 1, 0, 1, 0);
    add("rd_empty",   0, 0, 8'h00, 1, 0, 0, 8'h44, 0, 1, 0, 1, 1);
    add("rw_empty",   0, 1, 8'hA5, 1, 1, 0, 8'h44, 0, 0, 0, 1, 1);
    add("rdA5",       0, 0, 8'h00, 1, 0, 1, 8'hA5, 0, 1, 0, 1, 1);
    add("wr01",       0, 1, 8'h01, 0, 1, 0, 8'hA5, 0, 0, 0, 1, 1);
    add("wr02",       0, 1, 8'h02, 0, 2, 0, 8'hA5, 0, 0, 0, 1, 1);
    add("rw03",       0, 1, 8'h03, 1, 2, 1, 8'h01, 0, 0, 0, 1, 1);
    add("rw04",       0, 1, 8'h04, 1, 2, 1, 8'h02, 0, 0, 0, 1, 1);
    add("rw05",       0, 1, 8'h05, 1, 2, 1, 8'h03, 0, 0, 0, 1, 1);
    add("rw06",       0, 1, 8'h06, 1, 2, 1, 8'h04, 0, 0, 0, 1, 1);
    add("rw07",       0, 1, 8'h07, 1, 2, 1, 8'h05, 0, 0, 0, 1, 1);
    add("rw08",       0, 1, 8'h08, 1, 2, 1, 8'h06, 0, 0, 0, 1, 1);
    add("wr09",       0, 1, 8'h09, 0, 3, 0, 8'h06, 0, 0, 1, 1, 1);
    add("wr0A",       0, 1, 8'h0A, 0, 4, 0, 8'h06, 1, 0, 1, 1, 1);
    add("rw_full",    0, 1, 8'hBB, 1, 3, 1, 8'h07, 0, 0, 1, 1, 1);
    add("rst_mid",    1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0);
    add("wr5A",       0, 1, 8'h5A, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0);
    add("rd5A",       0, 0, 8'h00, 1, 0, 1, 8'h5A, 0, 1, 0, 0, 0);

    foreach (vecs[i]) begin
      cyc(vecs[i].rst, vecs[i].we, vecs[i].wd, vecs[i].re);
      chk(vecs[i].name, dut_obs(),
          pack(vecs[i].cnt, vecs[i].v, vecs[i].d, vecs[i].f,
               vecs[i].e, vecs[i].af, vecs[i].o, vecs[i].u));
    end

    // randomized traffic against the queue model
    cyc(1'b1, 1'b0, '0, 1'b0);
    q.delete();
    m_v = 1'b0; m_d = '0; m_o = 1'b0; m_u = 1'b0;
    chk("rand_reset", dut_obs(), pack(0, 0, 8'h00, 0, 1, 0, 0, 0));

    for (int n = 0; n < 400; n++) begin
      logic         r, we, re;
      logic [W-1:0] wd;
      bit           wok, rok;
      r  = ($urandom_range(0, 59) == 0);
      we = ($urandom_range(0, 99) < 55);
      re = ($urandom_range(0, 99) < 50);
      wd = W'($urandom);
      cyc(r, we, wd, re);
      if (r) begin
        q.delete();
        m_v = 1'b0; m_d = '0; m_o = 1'b0; m_u = 1'b0;
      end else begin
        wok = we && (q.size() < DEPTH);
        rok = re && (q.size() > 0);
        if (we && q.size() == DEPTH) m_o = 1'b1;
        if (re && q.size() == 0) m_u = 1'b1;
        m_v = rok;
        if (rok) m_d = q.pop_front();
        if (wok) q.push_back(wd);
      end
      chk($sformatf("rand%0d", n), dut_obs(),
          pack(q.size(), m_v, m_d, q.size() == DEPTH, q.size() == 0,
               q.size() >= AFL, m_o, m_u));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
